nonce_verifier: RTL
===================

// Module: nonce_verifier
// PURPOSE
//  Receive end of the miner's result interface: takes block, candidate nonce and target; recomputes micro-hash; reports pass/fail.
//  Sits downstream of system (miner) to independently confirm each reported nonce; also used standalone as golden checker.
//  Iterative: one hash round per clk; no pipelining; one verification in flight.
// PARAMETERS
//  ROUNDS      32        hash rounds per verification (counter width = $clog2(ROUNDS))
//  CNT_W       16        width of err_count (only with VERIFIER_ERR_CNT_EN)
// PORTS
//  clk         in   1    single clock, all logic on posedge
//  reset       in   1    asynchronous, active-high; clears all state
//  start       in   1    request; sampled only in IDLE
//  block       in   96   block bytes; byte n = block[8n+7:8n], n=0..11
//  nonce       in   32   candidate nonce; byte m = nonce[8m+7:8m], m=0..3
//  target      in   8    difficulty; pass iff H0 < target AND H1 < target
//  busy        out  1    high from cycle after accepted start through DONE
//  done        out  1    one-cycle pulse, result valid this cycle and held after
//  valid       out  1    1 = nonce meets target
//  hash        out  24   {H0,H1,H2} final hash
//  err_count   out  CNT_W  failed-verification count (only with VERIFIER_ERR_CNT_EN)
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, valid=0, hash=0, round=0, err_count=0.
//  Hash: W[0..11]=block bytes, W[12..15]=nonce bytes; W[i]=W[i-3] | (W[i-9]^W[i-14]), i=16..31.
//   H init H0=8'h01 H1=8'h89 H2=8'hFE. Round i: k=8'h99,x=H1^H2 for i<=16; k=8'hA1,x=H0^H1^H2 for i>16.
//   T=(x+k+W[i]) mod 256; H0'=H1^T; H1'=H2; H2'=H0^T. All adds 8-bit, carry dropped.
//  FSM: IDLE --start--> ROUND (latch block,nonce,target; load H init; round=0).
//   ROUND: one round/cycle; round==ROUNDS-1 -> DONE.
//   DONE: done=1 for 1 cycle; hash, valid registered; -> IDLE.
//  Latency: start sampled at edge N -> done high during cycle after edge N+ROUNDS+1 (33 clk for 32 rounds).
//  start while busy: ignored, no queueing; latched inputs unaffected by later input changes.
//  start held high: re-accepted in IDLE right after DONE (back-to-back, 1 idle cycle).
//  hash/valid hold last result until next DONE; cleared only by reset.
//  target=0 -> valid=0 always. target compare unsigned, strict less-than.
//  reset mid-ROUND: aborts immediately, no done pulse, outputs to reset values.
// CONFIGURATION
//  VERIFIER_ERR_CNT_EN defined: err_count port present; +1 in DONE when valid=0; saturates at all-ones.
//  Undefined: no err_count port, no counter logic; all other behaviour identical.
// STRUCTURE
//  Shared header micro_hash_defs.vh: H0/H1/H2 init, K_LO=8'h99, K_HI=8'hA1, K switch round (16), ROUNDS default,
//   FSM state encodings; same header used by the miner so both ends agree bit-exactly.
//  Sub-module micro_hash_round: combinational, in {H0,H1,H2,W,round} -> out {H0',H1',H2'}; shared with miner.
//  W schedule expanded combinationally from latched block/nonce in top level.
// TESTING
//  1 Reset release, no start -> busy=0, done=0, valid=0, hash=0 for 50 cycles.
//  2 block bytes 61,69,63,70,21,00,00,03,17,08,00,F3, target=10, nonce from miner run -> done at +33 clk, valid=1, hash equals miner hash.
//  3 Same block, nonce from test 2 XOR 32'h1, target=10 -> valid=0; target=0 with any nonce -> valid=0.
//  4 start pulsed again at cycles 5 and 20 of a run, inputs changed -> ignored; one done, result from originally latched inputs.
//  5 reset asserted at round 10 -> immediate IDLE, no done; new start then completes normally in 33 clk.
//  6 VERIFIER_ERR_CNT_EN, 3 failing + 2 passing runs with start held high -> err_count=3, back-to-back spacing 34 clk.

Source files
------------

// File: rtl/nonce_verifier_pkg.sv
// Shared micro-hash constants, FSM encoding and hash-state type; the miner imports the same package
// so that both ends agree bit-exactly on initial state, round keys and key-switch point.
package nonce_verifier_pkg;

    localparam int ROUNDS_DEF     = 32;
    localparam int K_SWITCH_ROUND = 16;

    localparam logic [7:0] H0_INIT = 8'h01;
    localparam logic [7:0] H1_INIT = 8'h89;
    localparam logic [7:0] H2_INIT = 8'hFE;
    localparam logic [7:0] K_LO    = 8'h99;
    localparam logic [7:0] K_HI    = 8'hA1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] h0;
        logic [7:0] h1;
        logic [7:0] h2;
    } hstate_t;

    function automatic hstate_t hstate_init();
        hstate_t h;
        h.h0 = H0_INIT;
        h.h1 = H1_INIT;
        h.h2 = H2_INIT;
        return h;
    endfunction

    // Strict unsigned less-than on both leading bytes; target 0 can never pass.
    function automatic logic meets_target(input hstate_t h, input logic [7:0] tgt);
        return (h.h0 < tgt) && (h.h1 < tgt);
    endfunction

endpackage

// File: rtl/nonce_verifier_micro_hash_round.sv
// One combinational micro-hash round: {H0,H1,H2} + schedule byte W[round] -> next {H0,H1,H2}.
// Zero latency, no flow control; the caller sequences rounds.
module nonce_verifier_micro_hash_round
    import nonce_verifier_pkg::*;
#(
    parameter int RND_W = 5
) (
    input  logic [23:0]      h_in,
    input  logic [7:0]       w,
    input  logic [RND_W-1:0] round,
    output logic [23:0]      h_out
);

    hstate_t    cur;
    hstate_t    nxt;
    logic [7:0] x;
    logic [7:0] k;
    logic [7:0] t;

    always_comb begin
        cur = hstate_t'(h_in);
        // Rounds up to and including the switch round mix only H1/H2.
        if (int'(round) > K_SWITCH_ROUND) begin
            x = cur.h0 ^ cur.h1 ^ cur.h2;
            k = K_HI;
        end else begin
            x = cur.h1 ^ cur.h2;
            k = K_LO;
        end
        t      = x + k + w;
        nxt.h0 = cur.h1 ^ t;
        nxt.h1 = cur.h2;
        nxt.h2 = cur.h0 ^ t;
        h_out  = nxt;
    end

endmodule

// File: rtl/nonce_verifier.sv
// Iterative nonce checker: latches block/nonce/target on start, one hash round per clk, done pulse ROUNDS+1 clk later.
// start is ignored while busy (no queueing); VERIFIER_ERR_CNT_EN adds a saturating failed-verification counter.
module nonce_verifier
    import nonce_verifier_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_DEF
`ifdef VERIFIER_ERR_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [95:0]       block,
    input  logic [31:0]       nonce,
    input  logic [7:0]        target,
    output logic              busy,
    output logic              done,
    output logic              valid,
    output logic [23:0]       hash
`ifdef VERIFIER_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0]  err_count
`endif
);

    localparam int RND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    state_t           state;
    state_t           state_d;
    logic [RND_W-1:0] round_q;
    logic [RND_W-1:0] round_d;
    hstate_t          h_q;
    hstate_t          h_d;
    logic [23:0]      h_next;
    logic [95:0]      block_q;
    logic [31:0]      nonce_q;
    logic [7:0]       target_q;
    logic [7:0]       w_cur;
    logic             latch_en;
    logic             finish;

    // Message schedule is rebuilt from the latched inputs every cycle; only W[round] is consumed.
    always_comb begin : w_sched
        logic [7:0] w [ROUNDS];
        for (int i = 0; i < 12; i++) begin
            w[i] = block_q[8*i +: 8];
        end
        for (int i = 0; i < 4; i++) begin
            w[12+i] = nonce_q[8*i +: 8];
        end
        for (int i = 16; i < ROUNDS; i++) begin
            w[i] = w[i-3] | (w[i-9] ^ w[i-14]);
        end
        w_cur = w[round_q];
    end

    nonce_verifier_micro_hash_round #(
        .RND_W (RND_W)
    ) u_round (
        .h_in  (h_q),
        .w     (w_cur),
        .round (round_q),
        .h_out (h_next)
    );

    always_comb begin
        state_d  = state;
        round_d  = round_q;
        h_d      = h_q;
        latch_en = 1'b0;
        finish   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_ROUND;
                    latch_en = 1'b1;
                    h_d      = hstate_init();
                    round_d  = '0;
                end
            end
            ST_ROUND: begin
                h_d     = hstate_t'(h_next);
                round_d = round_q + 1'b1;
                if (round_q == RND_W'(ROUNDS - 1)) begin
                    state_d = ST_DONE;
                    round_d = '0;
                end
            end
            ST_DONE: begin
                finish  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            round_q  <= '0;
            h_q      <= '0;
            block_q  <= '0;
            nonce_q  <= '0;
            target_q <= '0;
            done     <= 1'b0;
            valid    <= 1'b0;
            hash     <= '0;
        end else begin
            state   <= state_d;
            round_q <= round_d;
            h_q     <= h_d;
            done    <= finish;
            if (latch_en) begin
                block_q  <= block;
                nonce_q  <= nonce;
                target_q <= target;
            end
            // Result registers hold until the next completed verification.
            if (finish) begin
                hash  <= h_q;
                valid <= meets_target(h_q, target_q);
            end
        end
    end

    assign busy = (state != ST_IDLE);

`ifdef VERIFIER_ERR_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= '0;
        end else if (finish && !meets_target(h_q, target_q) && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end
`endif

endmodule
